// File: rtl/census_stream.sv
// Purpose: streaming census transform over a sliding WW x WH window built from internal line buffers.
// Latency: one cycle from the accept of a window's bottom-right pixel to out_valid/out_data.
// Backpressure: single output register; in_ready = out_ready || !out_valid, so a stall freezes input and output.
module census_stream #(
    parameter int WIDTH         = 32,
    parameter int WINDOW_WIDTH  = 5,
    parameter int WINDOW_HEIGHT = 5,
    parameter int IMG_WIDTH     = 640,
    parameter int IMG_HEIGHT    = 480
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [WIDTH-1:0]                      in_data,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [WIDTH-1:0]                      thresh,
    input  logic                                  mode,
    output logic [WINDOW_WIDTH*WINDOW_HEIGHT-1:0] out_data,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic                                  out_eof
);

    localparam int WW = WINDOW_WIDTH;
    localparam int WH = WINDOW_HEIGHT;
    localparam int NB = WW * WH;
    localparam int XW = $clog2(IMG_WIDTH);
    localparam int YW = $clog2(IMG_HEIGHT);
    localparam int CR = (WH - 1) / 2;
    localparam int CC = (WW - 1) / 2;

    localparam logic [XW-1:0] X_LAST  = XW'(IMG_WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST  = YW'(IMG_HEIGHT - 1);
    localparam logic [XW-1:0] X_FIRST = XW'(WW - 1);
    localparam logic [YW-1:0] Y_FIRST = YW'(WH - 1);

    // lbuf[0] holds the oldest stored line, lbuf[WH-2] the line just above the current one.
    logic [WIDTH-1:0] lbuf [WH-1][IMG_WIDTH];
    // win[r][c]: r=0 top/oldest line, c=0 leftmost/oldest column.
    logic [WIDTH-1:0] win  [WH][WW];
    logic [WIDTH-1:0] col  [WH];
    logic [WIDTH-1:0] nwin [WH][WW];

    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic          accept;
    logic          win_ok;
    logic          frame_end;
    logic [NB-1:0] census;
    logic [WIDTH:0] ctr;
    logic [WIDTH:0] bias;
    logic [WIDTH:0] sum;

    assign in_ready  = out_ready || !out_valid;
    assign accept    = in_valid && in_ready;
    // Windows only form once a full WW x WH block exists inside the current line/frame.
    assign win_ok    = (x >= X_FIRST) && (y >= Y_FIRST);
    assign frame_end = (x == X_LAST) && (y == Y_LAST);

    // New rightmost column: stored lines at this x, with the incoming pixel at the bottom.
    always_comb begin
        for (int r = 0; r < WH - 1; r++) begin
            col[r] = lbuf[r][x];
        end
        col[WH-1] = in_data;
    end

    // Window as it will look once the incoming column is shifted in.
    always_comb begin
        for (int r = 0; r < WH; r++) begin
            for (int c = 0; c < WW - 1; c++) begin
                nwin[r][c] = win[r][c+1];
            end
            nwin[r][WW-1] = col[r];
        end
    end

    // Census compare in WIDTH+1 bits so neighbour+threshold never wraps.
    always_comb begin
        census = '0;
        sum    = '0;
        ctr    = {1'b0, nwin[CR][CC]};
        bias   = mode ? {1'b0, thresh} : '0;
        for (int r = 0; r < WH; r++) begin
            for (int c = 0; c < WW; c++) begin
                sum               = {1'b0, nwin[r][c]} + bias;
                census[r*WW + c]  = (ctr > sum);
            end
        end
    end

    // Line buffers and window registers shift on every accept; contents need no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int r = 0; r < WH - 1; r++) begin
                lbuf[r][x] <= col[r+1];
            end
            for (int r = 0; r < WH; r++) begin
                for (int c = 0; c < WW; c++) begin
                    win[r][c] <= nwin[r][c];
                end
            end
        end
    end

    // Raster position of the next pixel; wraps per line and per frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            x <= '0;
            y <= '0;
        end else if (accept) begin
            if (x == X_LAST) begin
                x <= '0;
                y <= (y == Y_LAST) ? '0 : y + 1'b1;
            end else begin
                x <= x + 1'b1;
            end
        end
    end

    // Output register: load on a valid-window accept, otherwise drain on handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_eof   <= 1'b0;
            out_data  <= '0;
        end else if (accept && win_ok) begin
            out_valid <= 1'b1;
            out_eof   <= frame_end;
            out_data  <= census;
        end else if (out_ready) begin
            out_valid <= 1'b0;
            out_eof   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_census_stream.sv
module tb_census_stream;

    localparam int W  = 8;
    localparam int IW = 8;
    localparam int IH = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] in_data;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] thresh;
    logic         mode;
    logic [8:0]   out_data;
    logic         out_valid;
    logic         out_ready;
    logic         out_eof;

    census_stream #(
        .WIDTH(W), .WINDOW_WIDTH(3), .WINDOW_HEIGHT(3),
        .IMG_WIDTH(IW), .IMG_HEIGHT(IH)
    ) dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .thresh(thresh), .mode(mode),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_eof(out_eof)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int n_vec   = 0;
    int n_eof   = 0;
    int stall_cycles = 0;
    int stall_req = 0;
    bit rand_rdy = 0;
    bit gap_en   = 0;

    logic [9:0] exp_q [$];
    logic [8:0] got_q [$];

    // Reference model: the frame seen so far, addressed by raster position.
    logic [W-1:0] img [IH][IW];
    int mx = 0;
    int my = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Census computed straight from the stored image around (mx,my).
    task automatic model_accept(input logic [W-1:0] d, input logic [W-1:0] th, input logic m);
        logic [8:0] v;
        int cen;
        int nb;
        img[my][mx] = d;
        if (mx >= 2 && my >= 2) begin
            v   = '0;
            cen = int'(img[my-1][mx-1]);
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    nb = int'(img[my-2+r][mx-2+c]);
                    v[r*3+c] = (cen > nb + (m ? int'(th) : 0));
                end
            end
            exp_q.push_back({(mx == IW-1 && my == IH-1), v});
        end
        mx++;
        if (mx == IW) begin
            mx = 0;
            my = (my == IH-1) ? 0 : my + 1;
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the pixel is accepted.
    task automatic send_pix(input logic [W-1:0] d, input logic [W-1:0] th, input logic m);
        int n;
        if (gap_en) begin
            repeat ($urandom_range(0, 2)) begin
                in_valid = 1'b0;
                @(posedge clk); #1;
            end
        end
        in_valid = 1'b1;
        in_data  = d;
        thresh   = th;
        mode     = m;
        n = 0;
        while (1) begin
            @(negedge clk);
            if (in_ready) begin
                model_accept(d, th, m);
                @(posedge clk); #1;
                in_valid = 1'b0;
                break;
            end
            n++;
            if (n > 1000) begin
                check("in_ready_timeout", 32'd0, 32'd1);
                @(posedge clk); #1;
                in_valid = 1'b0;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    // kind: 0 constant 50, 1 ramp, 2 random, 3 single bright centre at (1,1).
    task automatic send_frame(input int kind, input logic [W-1:0] th, input logic m,
                              input int stall_at, input int npix);
        logic [W-1:0] p;
        logic [W-1:0] t;
        logic         mm;
        for (int i = 0; i < npix; i++) begin
            t  = th;
            mm = m;
            case (kind)
                0: p = 8'd50;
                1: p = 8'((i % IW) + 8 * (i / IW));
                2: begin
                    p  = 8'($urandom_range(0, 255));
                    t  = 8'($urandom_range(0, 15));
                    mm = 1'($urandom_range(0, 1));
                end
                4: p = 8'd200;
                default: p = ((i % IW) == 1 && (i / IW) == 1) ? 8'd255 : 8'd250;
            endcase
            if (i == stall_at) stall_req = 5;
            send_pix(p, t, mm);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 500) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        check("drain_empty", exp_q.size(), 0);
        @(posedge clk); #1;
    endtask

    task automatic start_test();
        got_q.delete();
        n_vec = 0;
        n_eof = 0;
    endtask

    task automatic check_all(input string nm, input logic [8:0] v);
        foreach (got_q[i]) check(nm, got_q[i], v);
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        mx = 0;
        my = 0;
        exp_q.delete();
    endtask

    // Output ready: forced low for stall windows, otherwise always-on or random.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (stall_req > 0) begin
                out_ready = 1'b0;
                stall_req--;
            end else if (rand_rdy) begin
                out_ready = ($urandom_range(0, 3) != 0);
            end else begin
                out_ready = 1'b1;
            end
        end
    end

    // Monitor: pops the scoreboard on each output handshake and checks hold behaviour.
    logic       held_v = 1'b0;
    logic [9:0] held_d;
    logic [9:0] e;
    always @(negedge clk) begin
        if (rst) begin
            held_v = 1'b0;
        end else begin
            if (held_v) begin
                check("hold_valid", out_valid, 1);
                check("hold_data", {out_eof, out_data}, held_d);
            end
            if (out_valid && !out_ready) begin
                check("stall_in_ready", in_ready, 0);
                stall_cycles++;
                held_v = 1'b1;
                held_d = {out_eof, out_data};
            end else begin
                held_v = 1'b0;
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("extra_vector", {out_eof, out_data}, 10'h3FF);
                end else begin
                    e = exp_q.pop_front();
                    check("vec_data", out_data, e[8:0]);
                    check("vec_eof", out_eof, e[9]);
                end
                n_vec++;
                if (out_eof) n_eof++;
                got_q.push_back(out_data);
            end
        end
    end

    initial begin
        in_valid = 1'b0;
        in_data  = '0;
        thresh   = '0;
        mode     = 1'b0;
        rst      = 1'b0;
        @(posedge clk); #1;
        do_reset();
        @(negedge clk);
        check("rst_valid", out_valid, 0);
        check("rst_eof", out_eof, 0);
        check("rst_data", out_data, 0);
        @(posedge clk); #1;

        // Constant image: all-zero vectors, eof only on the last.
        start_test();
        send_frame(0, 8'd0, 1'b0, -1, IW*IH);
        drain();
        check("t1_count", n_vec, 12);
        check("t1_eof", n_eof, 1);
        check_all("t1_val", 9'h000);

        // Ramp, plain and thresholded.
        start_test();
        send_frame(1, 8'd0, 1'b0, -1, IW*IH);
        drain();
        check("t2a_count", n_vec, 12);
        check_all("t2a_val", 9'h00F);
        start_test();
        send_frame(1, 8'd1, 1'b1, -1, IW*IH);
        drain();
        check("t2b_count", n_vec, 12);
        check_all("t2b_val", 9'h007);

        // Ramp with a 5-cycle output stall mid-stream.
        start_test();
        stall_cycles = 0;
        send_frame(1, 8'd0, 1'b0, 20, IW*IH);
        drain();
        check("t3_count", n_vec, 12);
        check_all("t3_val", 9'h00F);
        check("t3_stalled", (stall_cycles >= 4), 1);

        // Reset after 13 pixels of a different image, then a clean ramp frame.
        start_test();
        send_frame(4, 8'd0, 1'b0, -1, 13);
        do_reset();
        send_frame(1, 8'd0, 1'b0, -1, IW*IH);
        drain();
        check("t4_count", n_vec, 12);
        check("t4_eof", n_eof, 1);
        check_all("t4_val", 9'h00F);

        // Bright centre against near neighbours: threshold sum must not wrap.
        start_test();
        send_frame(3, 8'd10, 1'b1, -1, IW*IH);
        drain();
        check("t5a_first", (got_q.size() > 0) ? got_q[0] : 9'h1FF, 9'h000);
        start_test();
        send_frame(3, 8'd4, 1'b1, -1, IW*IH);
        drain();
        check("t5b_first", (got_q.size() > 0) ? got_q[0] : 9'h000, 9'h1EF);

        // Two back-to-back random frames with input gaps and random output ready.
        start_test();
        rand_rdy = 1;
        gap_en   = 1;
        send_frame(2, 8'd0, 1'b0, -1, 2*IW*IH);
        rand_rdy = 0;
        gap_en   = 0;
        drain();
        check("t6_count", n_vec, 24);
        check("t6_eof", n_eof, 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
